// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of requester, shared-memory and status signals
// for mem_arbiter.
//   m0_* / m1_* : requester 0 (CPU) and requester 1 (loader/DMA) request side
//                 (req, we, addr, wdata, funct3) and response side (ack, rdata)
//   mem_*       : shared memory port (write, addr, wdata, funct3, rdata)
//   grant, busy : arbiter status (one-hot owner, non-idle indicator)
// Modports:
//   slave  -- arbiter view (takes requests, drives memory and responses)
//   master -- environment view (requesters plus memory model)
interface mem_arbiter_if;
    logic        m0_req,    m1_req;
    logic        m0_we,     m1_we;
    logic [31:0] m0_addr,   m1_addr;
    logic [31:0] m0_wdata,  m1_wdata;
    logic [2:0]  m0_funct3, m1_funct3;
    logic        m0_ack,    m1_ack;
    logic [31:0] m0_rdata,  m1_rdata;

    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    logic [1:0]  grant;
    logic        busy;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_funct3, m1_funct3, mem_rdata,
        output m0_ack, m1_ack, m0_rdata, m1_rdata,
               mem_write, mem_addr, mem_wdata, mem_funct3, grant, busy
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_funct3, m1_funct3, mem_rdata,
        input  m0_ack, m1_ack, m0_rdata, m1_rdata,
               mem_write, mem_addr, mem_wdata, mem_funct3, grant, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester arbiter in front of a single shared memory.
// One transaction at a time: IDLE -> ACCESS -> (WAIT x READ_LAT) -> RESP.
// The winner's request is latched in IDLE, so requester inputs may change
// freely once a transaction is in flight.
// Parameters:
//   READ_LAT : memory read latency in cycles (1..3)
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_arbiter_if.slave (requesters, memory port, grant/busy)
// Optional feature:
//   ARB_ROUND_ROBIN_EN -- when defined, ties alternate between the ports;
//   otherwise port 0 always wins ties.
module mem_arbiter #(
    parameter int READ_LAT = 1
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

    state_t      state, state_nx;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [2:0]  lat_funct3;
    logic [1:0]  owner;
    logic [1:0]  wait_cnt;
    logic [31:0] rdata_q;
    logic [1:0]  win;

`ifdef ARB_ROUND_ROBIN_EN
    // Index of the port granted most recently; resets to 1 so port 0
    // takes the first tie.
    logic last_grant;

    always_comb begin
        win = 2'b00;
        if (bus.m0_req && bus.m1_req)
            win = last_grant ? 2'b01 : 2'b10;
        else if (bus.m0_req)
            win = 2'b01;
        else if (bus.m1_req)
            win = 2'b10;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            last_grant <= 1'b1;
        else if (state == IDLE && win != 2'b00)
            last_grant <= win[1];
    end
`else
    always_comb begin
        win = 2'b00;
        if (bus.m0_req)
            win = 2'b01;
        else if (bus.m1_req)
            win = 2'b10;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win != 2'b00) state_nx = ACCESS;
            ACCESS:  state_nx = lat_we ? RESP : WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Request latch, wait counter and read-data capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_funct3 <= '0;
            owner      <= '0;
            wait_cnt   <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win != 2'b00) begin
                        owner      <= win;
                        lat_we     <= win[0] ? bus.m0_we     : bus.m1_we;
                        lat_addr   <= win[0] ? bus.m0_addr   : bus.m1_addr;
                        lat_wdata  <= win[0] ? bus.m0_wdata  : bus.m1_wdata;
                        lat_funct3 <= win[0] ? bus.m0_funct3 : bus.m1_funct3;
                        rdata_q    <= '0;
                    end
                end
                ACCESS: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    // Memory data is valid on the edge closing the last WAIT cycle
                    if (wait_cnt == WAIT_LAST)
                        rdata_q <= bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state only, so reset clears them immediately
    always_comb begin
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_funct3 = '0;
        bus.m0_ack     = 1'b0;
        bus.m1_ack     = 1'b0;
        bus.m0_rdata   = '0;
        bus.m1_rdata   = '0;
        bus.grant      = 2'b00;
        bus.busy       = 1'b0;
        case (state)
            ACCESS, WAIT: begin
                bus.mem_write  = (state == ACCESS) && lat_we;
                bus.mem_addr   = lat_addr;
                bus.mem_wdata  = lat_wdata;
                bus.mem_funct3 = lat_funct3;
                bus.grant      = owner;
                bus.busy       = 1'b1;
            end
            RESP: begin
                bus.grant  = owner;
                bus.busy   = 1'b1;
                bus.m0_ack = owner[0];
                bus.m1_ack = owner[1];
                if (!lat_we) begin
                    bus.m0_rdata = owner[0] ? rdata_q : '0;
                    bus.m1_rdata = owner[1] ? rdata_q : '0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter.
// Two instances: dut1 (READ_LAT=1) and dut3 (READ_LAT=3), sharing clk/reset.
// Cycle numbering: cycle 0 is the IDLE cycle in which req is first presented.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_arbiter_if ifa ();
    mem_arbiter_if ifb ();

    mem_arbiter #(.READ_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(ifa));
    mem_arbiter #(.READ_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; sample/drive 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.m0_req = 0; ifa.m1_req = 0; ifa.m0_we = 0; ifa.m1_we = 0;
        ifa.m0_addr = '0; ifa.m1_addr = '0; ifa.m0_wdata = '0; ifa.m1_wdata = '0;
        ifa.m0_funct3 = '0; ifa.m1_funct3 = '0; ifa.mem_rdata = '0;
        ifb.m0_req = 0; ifb.m1_req = 0; ifb.m0_we = 0; ifb.m1_we = 0;
        ifb.m0_addr = '0; ifb.m1_addr = '0; ifb.m0_wdata = '0; ifb.m1_wdata = '0;
        ifb.m0_funct3 = '0; ifb.m1_funct3 = '0; ifb.mem_rdata = '0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] agg;
        reset = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if ({ifa.busy, ifa.grant, ifa.mem_write, ifa.m0_ack, ifa.m1_ack} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got busy=%b grant=%b wr=%b ack=%b%b required all 0",
                     ifa.busy, ifa.grant, ifa.mem_write, ifa.m0_ack, ifa.m1_ack);
        end
        agg = ifa.mem_addr | ifa.mem_wdata | ifa.m0_rdata | ifa.m1_rdata | 32'(ifa.mem_funct3);
        checks++;
        if (agg !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got or-of-data=%h required 00000000", agg);
        end
        checks++;
        if (ifb.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy3: got %b required 0", ifb.busy);
        end
        #9;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        int wr_cnt = 0, ack_cyc = 0, ack_cnt = 0;
        logic [31:0] wr_addr = '0, wr_data = '0, rd_at_ack = 'x;
        logic [1:0]  g1 = '0;
        logic        other_ack = 0;
        ifa.m0_req = 1; ifa.m0_we = 1; ifa.m0_addr = 32'h10;
        ifa.m0_wdata = 32'hDEADBEEF; ifa.m0_funct3 = 3'b010;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin
                ifa.m0_req = 0;
                g1 = ifa.grant;
            end
            if (ifa.mem_write) begin
                wr_cnt++;
                wr_addr = ifa.mem_addr;
                wr_data = ifa.mem_wdata;
            end
            if (ifa.m0_ack) begin
                ack_cnt++;
                if (ack_cyc == 0) ack_cyc = c;
                rd_at_ack = ifa.m0_rdata;
            end
            if (ifa.m1_ack) other_ack = 1;
        end
        checks++;
        if (wr_cnt !== 1) begin failures++; $display("FAIL wr_pulse_len: got %0d required 1", wr_cnt); end
        checks++;
        if (wr_addr !== 32'h10) begin failures++; $display("FAIL wr_addr: got %h required 00000010", wr_addr); end
        checks++;
        if (wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_data: got %h required deadbeef", wr_data); end
        checks++;
        if (g1 !== 2'b01) begin failures++; $display("FAIL wr_grant: got %b required 01", g1); end
        checks++;
        if (ack_cyc !== 2 || ack_cnt !== 1) begin
            failures++;
            $display("FAIL wr_ack_cycle: got cycle %0d count %0d required cycle 2 count 1", ack_cyc, ack_cnt);
        end
        checks++;
        if (rd_at_ack !== 32'h0) begin failures++; $display("FAIL wr_rdata: got %h required 00000000", rd_at_ack); end
        checks++;
        if (other_ack !== 1'b0) begin failures++; $display("FAIL wr_m1_ack: got 1 required 0"); end
    endtask

    task automatic test_single_read();
        int ack_cyc = 0;
        logic [31:0] rd1 = 'x, rd0 = 'x;
        logic        saw_wr = 0;
        ifa.m1_req = 1; ifa.m1_we = 0; ifa.m1_addr = 32'h10; ifa.m1_funct3 = 3'b010;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) ifa.m1_req = 0;
            // Only the WAIT-cycle value is the real read data
            ifa.mem_rdata = (c == 2) ? 32'hDEADBEEF : 32'h0BAD0BAD;
            if (ifa.mem_write) saw_wr = 1;
            if (ifa.m1_ack && ack_cyc == 0) begin
                ack_cyc = c;
                rd1 = ifa.m1_rdata;
                rd0 = ifa.m0_rdata;
            end
        end
        ifa.mem_rdata = '0;
        checks++;
        if (ack_cyc !== 3) begin failures++; $display("FAIL rd_ack_cycle: got %0d required 3", ack_cyc); end
        checks++;
        if (rd1 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_m1_rdata: got %h required deadbeef", rd1); end
        checks++;
        if (rd0 !== 32'h0) begin failures++; $display("FAIL rd_m0_rdata: got %h required 00000000", rd0); end
        checks++;
        if (saw_wr !== 1'b0) begin failures++; $display("FAIL rd_mem_write: got 1 required 0"); end
    endtask

    task automatic test_read_lat3_isolation();
        int addr_cnt = 0, ack_cyc = 0;
        logic        bad_addr = 0;
        logic [2:0]  f3 = '0;
        logic [31:0] rd = 'x, addr_at_ack = 'x;
        ifb.m0_req = 1; ifb.m0_we = 0; ifb.m0_addr = 32'h10; ifb.m0_funct3 = 3'b100;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin
                ifb.m0_req = 0;
                f3 = ifb.mem_funct3;
            end
            if (c == 2) ifb.m0_addr = 32'h20;
            ifb.mem_rdata = (c == 4) ? 32'h12345678 : 32'hFFFF0000;
            if (ifb.mem_addr === 32'h10) addr_cnt++;
            else if (ifb.mem_addr !== 32'h0) bad_addr = 1;
            if (ifb.m0_ack && ack_cyc == 0) begin
                ack_cyc = c;
                rd = ifb.m0_rdata;
                addr_at_ack = ifb.mem_addr;
            end
        end
        ifb.mem_rdata = '0;
        ifb.m0_addr = '0;
        checks++;
        if (addr_cnt !== 4) begin failures++; $display("FAIL lat3_addr_hold: got %0d cycles required 4", addr_cnt); end
        checks++;
        if (bad_addr !== 1'b0) begin failures++; $display("FAIL isolation: got foreign mem_addr required only 00000010"); end
        checks++;
        if (ack_cyc !== 5) begin failures++; $display("FAIL lat3_ack_cycle: got %0d required 5", ack_cyc); end
        checks++;
        if (rd !== 32'h12345678) begin failures++; $display("FAIL lat3_rdata: got %h required 12345678", rd); end
        checks++;
        if (addr_at_ack !== 32'h0) begin failures++; $display("FAIL resp_addr_zero: got %h required 00000000", addr_at_ack); end
        checks++;
        if (f3 !== 3'b100) begin failures++; $display("FAIL funct3_pass: got %b required 100", f3); end
    endtask

    task automatic test_tie();
        logic [1:0] seen [4];
        logic [1:0] exp  [4];
        logic [1:0] prev = 2'b00;
        int n = 0;
`ifdef ARB_ROUND_ROBIN_EN
        exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        pulse_reset();
        ifa.m0_req = 1; ifa.m0_we = 1; ifa.m0_addr = 32'h40; ifa.m0_wdata = 32'h1;
        ifa.m1_req = 1; ifa.m1_we = 1; ifa.m1_addr = 32'h80; ifa.m1_wdata = 32'h2;
        for (int c = 1; c <= 20 && n < 4; c++) begin
            tick();
            if (ifa.grant !== 2'b00 && prev === 2'b00) begin
                seen[n] = ifa.grant;
                n++;
            end
            prev = ifa.grant;
        end
        ifa.m0_req = 0; ifa.m1_req = 0;
        for (int c = 0; c < 4; c++) tick();
        checks++;
        if (n !== 4) begin
            failures++;
            $display("FAIL tie_count: got %0d transactions required 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seen[i] !== exp[i]) begin
                    failures++;
                    $display("FAIL tie_grant[%0d]: got %b required %b", i, seen[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int ack_cnt = 0, busy_cnt = 0;
        ifa.m0_req = 1; ifa.m0_we = 1; ifa.m0_addr = 32'h10; ifa.m0_wdata = 32'hCAFEF00D;
        tick();
        checks++;
        if (ifa.mem_write !== 1'b1) begin failures++; $display("FAIL rst_pre_write: got %b required 1", ifa.mem_write); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ifa.mem_write !== 1'b0) begin failures++; $display("FAIL rst_write_drop: got %b required 0", ifa.mem_write); end
        checks++;
        if (ifa.busy !== 1'b0 || ifa.grant !== 2'b00 || ifa.mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL rst_async: got busy=%b grant=%b addr=%h required 0/00/00000000",
                     ifa.busy, ifa.grant, ifa.mem_addr);
        end
        ifa.m0_req = 0;
        #1;
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ifa.m0_ack || ifa.m1_ack) ack_cnt++;
            if (ifa.busy) busy_cnt++;
        end
        checks++;
        if (ack_cnt !== 0) begin failures++; $display("FAIL rst_no_ack: got %0d acks required 0", ack_cnt); end
        checks++;
        if (busy_cnt !== 0) begin failures++; $display("FAIL rst_idle: got %0d busy cycles required 0", busy_cnt); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_single_write();
        test_single_read();
        test_read_lat3_isolation();
        test_tie();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
